// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction loader: FSM encoding, default
// memory geometry and the number of stream bytes per instruction word.
package inst_loader_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian stream bytes into 32-bit words.
// word/word_done are registered: word_done pulses for one cycle after the
// last byte of a word is accepted, and word holds that word until the next
// completion so the memory write sees a stable value.
module word_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_done,
  output logic [31:0] word
);

  logic [BIDX_W-1:0] byte_idx;
  logic [23:0]       partial;

  assign last_byte = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

  // Byte index, partial-word lanes and the completed-word register
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx  <= '0;
      partial   <= '0;
      word_done <= 1'b0;
      word      <= '0;
    end else if (clear) begin
      byte_idx  <= '0;
      partial   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (byte_valid) begin
        if (last_byte) begin
          // The final byte goes straight to the top lane of the output word
          word      <= {byte_data, partial};
          word_done <= 1'b1;
          byte_idx  <= '0;
          partial   <= '0;
        end else begin
          for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
            if (byte_idx == BIDX_W'(k)) begin
              partial[8*k +: 8] <= byte_data;
            end
          end
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Streams a program image byte-by-byte into instruction memory while holding
// the core. The word counter runs down to a terminal count of one; the write
// address runs up from zero.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start with a non-zero word_count
//   ST_LOAD   | accepting bytes, one memory write per four bytes
//   ST_FINISH | final write in flight, done pulse, back to idle
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              core_hold,
  output logic              done
);

  state_t              state, state_nxt;
  logic [ADDR_W:0]     words_left;
  logic [ADDR_W-1:0]   word_addr;
  logic                start_ok;
  logic                accept;
  logic                last_byte;
  logic                word_done;
  logic [31:0]         word;

  assign start_ok = (state == ST_IDLE) && start && (word_count != '0);
  assign accept   = in_valid && in_ready;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (accept),
    .byte_data  (in_data),
    .last_byte  (last_byte),
    .word_done  (word_done),
    .word       (word)
  );

  assign wr_en     = word_done;
  assign wr_data   = word;
  assign core_hold = busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_byte && (words_left == (ADDR_W+1)'(1))) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word down-counter, running write address and registered write address
  always_ff @(posedge clk) begin
    if (rst) begin
      words_left <= '0;
      word_addr  <= '0;
      wr_addr    <= '0;
    end else if (start_ok) begin
      words_left <= word_count;
      word_addr  <= '0;
    end else if (accept && last_byte) begin
      // wr_addr is captured alongside the packer's word so both line up with wr_en
      wr_addr    <= word_addr;
      word_addr  <= word_addr + 1'b1;
      words_left <= words_left - 1'b1;
    end
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (256 words).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 word_count  input  ADDR_W+1  number of 32-bit words to load, 1..256; sampled with start.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  8  program byte, little-endian within each word.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_W  instruction-memory word address.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 busy  output  1  load in progress.
REQ-013 core_hold  output  1  holds fetch pc and pipeline while memory is being rewritten; equals busy.
REQ-014 done  output  1  one-cycle pulse marking completion of a load.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and FINISH, encoded as shared-package constants.
REQ-016 In IDLE, start=1 with word_count!=0 SHALL latch word_count, clear word address and byte index, and enter LOAD next cycle; start with word_count=0 SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in LOAD; a byte is accepted only when in_valid&in_ready.
REQ-018 in_valid in IDLE or FINISH SHALL NOT consume a byte or change any state.
REQ-019 Accepted byte k (k=0..3) of a word SHALL be placed at wr_data bits [8k+7:8k].
REQ-020 On acceptance of byte 3, wr_en SHALL be 1 in the next cycle, with wr_addr equal to the current word address and wr_data equal to the assembled word.
REQ-021 After each write, the word address SHALL increment by 1 and the byte index SHALL return to 0.
REQ-022 Bytes of the next word SHALL be acceptable in the same cycle wr_en is asserted for the previous word, giving a sustained throughput of 1 byte/cycle with no bubbles.
REQ-023 When byte 3 of word (word_count-1) is accepted, the FSM SHALL enter FINISH; FINISH SHALL last exactly one cycle, during which the final wr_en=1 and done=1.
REQ-024 FINISH SHALL return unconditionally to IDLE.
REQ-025 busy and core_hold SHALL be 1 in LOAD and FINISH and 0 in IDLE.
REQ-026 With word_count=256, the final write SHALL go to address 255; the address SHALL NOT wrap within a load.
REQ-027 start asserted in LOAD or FINISH SHALL be ignored.
REQ-028 Gaps in in_valid SHALL only stall progress; they SHALL NOT corrupt partial words.
REQ-029 wr_en SHALL never be 1 in IDLE.

Reset
REQ-030 With rst=1 at a clock edge, the next state SHALL be IDLE, with in_ready=0, wr_en=0, busy=0, core_hold=0, done=0, wr_addr=0 and wr_data=0.
REQ-031 Reset during LOAD SHALL discard any partial word without issuing a write; words already written remain in memory.

Structure
REQ-032 The FSM state constants, ADDR_W default and byte-per-word constant (4) SHALL live in the shared processor package.
REQ-033 Byte-to-word assembly (byte index, shift/placement, word-complete flag) SHALL be one sub-module, word_packer; counters and the FSM stay in inst_loader.

Verification
REQ-034 start, word_count=1, bytes 13,00,00,00 on consecutive cycles -> wr_en one cycle with wr_addr=0, wr_data=0x00000013, done=1 the same cycle, busy=0 the next cycle.
REQ-035 word_count=3, 12 back-to-back bytes -> writes at addresses 0,1,2 on cycles 5, 9 and 13 after LOAD entry, with in_ready continuously 1 during LOAD.
REQ-036 word_count=2, in_valid toggled 1/0 every cycle, bytes EF,BE,AD,DE,67,45,23,01 -> writes 0xDEADBEEF@0 and 0x01234567@1, and no extra writes.
REQ-037 word_count=256 with a random stream -> 256 writes, last at address 255, a single done pulse, and in_ready=0 afterwards.
REQ-038 rst after 6 bytes of a 4-word load -> exactly one write (addr 0); outputs at reset values next cycle; a new start reloads from address 0.
REQ-039 start with word_count=0, and in_valid=1 while IDLE -> no state change, in_ready=0, busy=0, no wr_en.
